pixel_write_buffer: RTL and testbench

Sits directly downstream of mandelbrot_top. Captures its pixel write stream (mem_we / mem_write_address / mem_write_data) into a small FIFO and drains it to the VGA SRAM through an Avalon-MM write master that honours waitrequest. Gates the solver's done pulse so frame_done asserts only after every accepted pixel has reached memory. Flags overflows and out-of-range addresses.

---
 rtl/pixel_write_buffer.sv | 161 ++++++++++++++++
 tb/tb_pixel_write_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: FIFO between the fractal solver and the VGA SRAM,
// drained through an Avalon-MM write master; gates frame_done on drain.
module pixel_write_buffer #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int MEM_MAX = 307200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_start,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  output logic              almost_full,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_write,
  input  logic              sram_waitrequest,
  output logic              frame_done,
  output logic              overflow,
  output logic              range_err,
  output logic [ADDR_W-1:0] pixels_written
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(DEPTH - 2);
  localparam logic [ADDR_W:0] MAX_C = (ADDR_W + 1)'(MEM_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     cnt_rem;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              rng_q, rng_d;
  logic [ADDR_W-1:0] pw_q, pw_d;
  logic              af_q, af_d;
  logic              done_q;
  state_e            state_q, state_d;

  logic              in_ok;
  logic              pop;
  logic              push;
  logic              rise;
  logic [EW-1:0]     head;

  always_comb begin
    in_ok    = {1'b0, in_address} < MAX_C;
    pop      = wr_q & ~sram_waitrequest;
    push     = in_we & in_ok & ((count_q != FULL_C) | pop);
    rise     = in_done & ~done_q;
    cnt_rem  = count_q - CW'(pop);
    count_d  = cnt_rem + CW'(push);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // An entry pushed into an otherwise empty FIFO is forwarded directly
    head     = (cnt_rem == '0) ? {in_address, in_data}
                               : mem_q[rd_ptr_d];
    wr_d     = (count_d != '0);
    addr_d   = addr_q;
    data_d   = data_q;
    if (wr_d) begin
      {addr_d, data_d} = head;
    end
    af_d = (count_d >= AF_C);
  end

  always_comb begin
    ovf_d = ovf_q;
    rng_d = rng_q;
    pw_d  = pw_q;
    if (in_start) begin
      ovf_d = 1'b0;
      rng_d = 1'b0;
      pw_d  = '0;
    end else if (pop && (pw_q != '1)) begin
      pw_d = pw_q + 1'b1;
    end
    if (in_we && in_ok && !push) begin
      ovf_d = 1'b1;
    end
    if (in_we && !in_ok) begin
      rng_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_start) state_d = S_RUN;
      S_RUN:   if (rise) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  if (in_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (in_start) begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_address, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      rng_q    <= 1'b0;
      pw_q     <= '0;
      af_q     <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      rng_q    <= rng_d;
      pw_q     <= pw_d;
      af_q     <= af_d;
      done_q   <= in_done;
      state_q  <= state_d;
    end
  end

  assign sram_write     = wr_q;
  assign sram_address   = addr_q;
  assign sram_writedata = data_q;
  assign overflow       = ovf_q;
  assign range_err      = rng_q;
  assign pixels_written = pw_q;
  assign almost_full    = af_q;
  assign frame_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer: directed pushes queue expected
// beats, a negedge monitor checks every accepted Avalon write.
module tb_pixel_write_buffer;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_start;
  logic              in_we;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_data;
  logic              in_done;
  logic              almost_full;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_writedata;
  logic              sram_write;
  logic              sram_waitrequest;
  logic              frame_done;
  logic              overflow;
  logic              range_err;
  logic [ADDR_W-1:0] pixels_written;

  always #5 clk = ~clk;

  pixel_write_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH(16),
    .MEM_MAX(307200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_start(in_start),
    .in_we(in_we),
    .in_address(in_address),
    .in_data(in_data),
    .in_done(in_done),
    .almost_full(almost_full),
    .sram_address(sram_address),
    .sram_writedata(sram_writedata),
    .sram_write(sram_write),
    .sram_waitrequest(sram_waitrequest),
    .frame_done(frame_done),
    .overflow(overflow),
    .range_err(range_err),
    .pixels_written(pixels_written)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h",
               nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d,
                      input bit keep);
    in_we = 1'b1;
    in_address = a;
    in_data = d;
    if (keep) exp_q.push_back('{a: a, d: d});
    tick();
    in_we = 1'b0;
  endtask

  task automatic start_pulse();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  // Monitor: pops one expected beat per accepted write; checks hold
  logic              pv = 1'b0;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] pd;

  always @(negedge clk) begin
    if (!reset) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        chk("hold_write", 32'(sram_write), 32'd1);
        chk("hold_addr", 32'(sram_address), 32'(pa));
        chk("hold_data", 32'(sram_writedata), 32'(pd));
      end
      if (sram_write && !sram_waitrequest) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: actual addr=0x%0h required no beat",
                   sram_address);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_addr", 32'(sram_address), 32'(mon_e.a));
          chk("beat_data", 32'(sram_writedata), 32'(mon_e.d));
        end
      end
      pv = sram_write && sram_waitrequest;
      pa = sram_address;
      pd = sram_writedata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc;
    bit bt;
    reset = 1'b0;
    in_start = 1'b0;
    in_we = 1'b0;
    in_address = '0;
    in_data = '0;
    in_done = 1'b0;
    sram_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst_write", 32'(sram_write), 32'd0);
    chk("rst_addr", 32'(sram_address), 32'd0);
    chk("rst_data", 32'(sram_writedata), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rng", 32'(range_err), 32'd0);
    chk("rst_pix", 32'(pixels_written), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    reset = 1'b1;
    tick();

    // Four back-to-back pushes, no stall
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      push(ADDR_W'(i), DATA_W'(8'h10 + i), 1'b1);
      chk("b2b_write", 32'(sram_write), 32'd1);
    end
    tick();
    chk("b2b_idle", 32'(sram_write), 32'd0);
    chk("b2b_pix", 32'(pixels_written), 32'd4);
    chk("b2b_ovf", 32'(overflow), 32'd0);
    chk("b2b_rng", 32'(range_err), 32'd0);

    // Single entry held under waitrequest
    sram_waitrequest = 1'b1;
    push(19'h100, 8'hAA, 1'b1);
    repeat (10) tick();
    chk("wait_addr", 32'(sram_address), 32'h100);
    chk("wait_data", 32'(sram_writedata), 32'hAA);
    chk("wait_pix", 32'(pixels_written), 32'd4);
    sram_waitrequest = 1'b0;
    tick();
    tick();
    chk("wait_idle", 32'(sram_write), 32'd0);
    chk("wait_pix2", 32'(pixels_written), 32'd5);

    // Overflow: 18 pushes into 16 entries
    start_pulse();
    chk("start_pix", 32'(pixels_written), 32'd0);
    sram_waitrequest = 1'b1;
    for (int i = 0; i < 18; i++) begin
      push(ADDR_W'(32'h200 + i), DATA_W'(i), i < 16);
    end
    tick();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_af", 32'(almost_full), 32'd1);
    sram_waitrequest = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_pix", 32'(pixels_written), 32'd16);
    chk("ovf_af2", 32'(almost_full), 32'd0);

    // Out-of-range address, then last valid address
    push(19'd307200, 8'h55, 1'b0);
    tick();
    chk("rng_flag", 32'(range_err), 32'd1);
    chk("rng_nowrite", 32'(sram_write), 32'd0);
    push(19'd307199, 8'h66, 1'b1);
    tick();
    chk("rng_edge_pix", 32'(pixels_written), 32'd17);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    start_pulse();
    chk("rng_clr", 32'(range_err), 32'd0);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Drain gating of frame_done
    sram_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(ADDR_W'(32'h400 + i), DATA_W'(8'h80 + i), 1'b1);
    end
    chk("fd_pre", 32'(frame_done), 32'd0);
    in_done = 1'b1;
    tick();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      sram_waitrequest = (i % 3 == 1);
      bt = sram_write && !sram_waitrequest;
      chk("fd_early", 32'(frame_done), 32'd0);
      tick();
      if (bt) acc++;
      if (acc == 5) begin
        chk("fd_after", 32'(frame_done), 32'd1);
        break;
      end
    end
    chk("fd_beats", 32'(acc), 32'd5);
    sram_waitrequest = 1'b0;
    repeat (3) tick();
    chk("fd_hold", 32'(frame_done), 32'd1);
    chk("fd_pix", 32'(pixels_written), 32'd5);
    in_done = 1'b0;
    start_pulse();
    chk("fd_clr", 32'(frame_done), 32'd0);

    // Reset in the middle of a burst
    sram_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(ADDR_W'(32'h500 + i), DATA_W'(8'hC0 + i), 1'b1);
    end
    sram_waitrequest = 1'b0;
    tick();
    tick();
    chk("burst_beats", 32'(exp_q.size()), 32'd6);
    reset = 1'b0;
    sram_waitrequest = 1'b1;
    exp_q.delete();
    tick();
    chk("mrst_write", 32'(sram_write), 32'd0);
    chk("mrst_addr", 32'(sram_address), 32'd0);
    chk("mrst_data", 32'(sram_writedata), 32'd0);
    chk("mrst_pix", 32'(pixels_written), 32'd0);
    chk("mrst_af", 32'(almost_full), 32'd0);
    chk("mrst_fd", 32'(frame_done), 32'd0);
    reset = 1'b1;
    sram_waitrequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_quiet", 32'(sram_write), 32'd0);
    end
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
